// File: rtl/crc16_serial_if.sv
// Serial data-line bundle between the SD DAT-line driver and one CRC-16 unit.
// The driver is the master: it supplies the data bit and the unload select, and it consumes the CRC bit.
interface crc16_serial_if;
  logic idata;
  logic iunload;
  logic ocrc;

  modport master (
    output idata,
    output iunload,
    input  ocrc
  );

  modport slave (
    input  idata,
    input  iunload,
    output ocrc
  );
endinterface

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16-CCITT (x^16+x^12+x^5+1) generator/checker for one SD DAT line.
// Optional macro CRC16_ASSERT_EN adds simulation-only input checks; it changes no logic and no ports.

`ifdef CRC16_ASSERT_EN
module crc16_serial_checker (
  input logic iclk,
  input logic irst,
  input logic idata,
  input logic iunload
);
  int unload_run;

  // Flag unknown inputs and unload runs longer than the 16-bit CRC
  always @(posedge iclk or posedge irst) begin
    if (irst) begin
      unload_run <= 0;
    end else begin
      if ($isunknown(idata) || $isunknown(iunload)) begin
        $error("crc16_serial: idata/iunload unknown at clock edge");
      end else begin
        unload_run <= unload_run;
      end
      if (iunload === 1'b1) begin
        unload_run <= unload_run + 1;
        if (unload_run + 1 > 16) begin
          $warning("crc16_serial: iunload high for more than 16 consecutive edges");
        end else begin
          unload_run <= unload_run + 1;
        end
      end else begin
        unload_run <= 0;
      end
    end
  end
endmodule
`endif

module crc16_serial #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'h0000
) (
  input logic          iclk,
  input logic          irst,
  crc16_serial_if.slave bus
);

  // Unload mode shifts with zero fill and no feedback, so idata is ignored there.
  function automatic logic [15:0] crc_step(
    input logic [15:0] crc,
    input logic        bit_in,
    input logic        unload
  );
    logic        fb;
    logic [15:0] shifted;
    shifted = {crc[14:0], 1'b0};
    fb      = bit_in ^ crc[15];
    if (unload) begin
      crc_step = shifted;
    end else if (fb) begin
      crc_step = shifted ^ POLY;
    end else begin
      crc_step = shifted;
    end
  endfunction

  logic [15:0] crc_r;
  logic [15:0] crc_next_s;

  // Next-state selection between accumulate and unload
  always_comb begin
    crc_next_s = crc_step(crc_r, bus.idata, bus.iunload);
  end

  // CRC register; the parent pulses irst between blocks to restart from INIT
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      crc_r <= INIT;
    end else begin
      crc_r <= crc_next_s;
    end
  end

  assign bus.ocrc = crc_r[15];

`ifdef CRC16_ASSERT_EN
  crc16_serial_checker u_checker (
    .iclk    (iclk),
    .irst    (irst),
    .idata   (bus.idata),
    .iunload (bus.iunload)
  );
`endif

endmodule

// File: tb/tb_crc16_serial.sv
// Directed self-checking bench for crc16_serial against known CRC-16/XMODEM values.
module tb_crc16_serial;
  logic iclk;
  logic irst;
  int   n_tests;
  int   n_fail;

  crc16_serial_if bus ();

  crc16_serial dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus.slave)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Apply one bit and wait until just after the rising edge.
  task automatic clk_bit(input logic d, input logic u);
    bus.idata   = d;
    bus.iunload = u;
    @(posedge iclk);
    #1;
  endtask

  task automatic pulse_reset();
    irst = 1'b1;
    #2;
    irst = 1'b0;
  endtask

  // Unload 16 bits, capturing ocrc before each unload edge (idata driven 1 to prove it is ignored).
  task automatic unload16(output logic [15:0] word);
    word = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      word = {word[14:0], bus.ocrc};
      clk_bit(1'b1, 1'b1);
    end
  endtask

  task automatic feed_string();
    logic [7:0] msg [9];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int b = 0; b < 9; b++) begin
      for (int i = 7; i >= 0; i--) begin
        clk_bit(msg[b][i], 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] w;
    n_tests++;
    if (bus.ocrc !== 1'b0) begin
      n_fail++; $display("FAIL reset_state ocrc got %b want 0", bus.ocrc);
    end
    clk_bit(1'b1, 1'b0);
    clk_bit(1'b0, 1'b0);
    clk_bit(1'b0, 1'b0);
    clk_bit(1'b0, 1'b0);
    n_tests++;
    if (bus.ocrc !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_msb got %b want 1", bus.ocrc);
    end
    #2;
    irst = 1'b1;
    #1;
    n_tests++;
    if (bus.ocrc !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got %b want 0", bus.ocrc);
    end
    bus.idata = 1'b1;
    bus.iunload = 1'b0;
    @(posedge iclk);
    #1;
    n_tests++;
    if (bus.ocrc !== 1'b0) begin
      n_fail++; $display("FAIL reset_held got %b want 0", bus.ocrc);
    end
    irst = 1'b0;
    clk_bit(1'b1, 1'b0);
    unload16(w);
    n_tests++;
    if (w !== 16'h1021) begin
      n_fail++; $display("FAIL after_reset_crc got %h want 1021", w);
    end
  endtask

  task automatic test_single_bit();
    logic [15:0] w;
    int bad;
    pulse_reset();
    clk_bit(1'b1, 1'b0);
    unload16(w);
    n_tests++;
    if (w !== 16'h1021) begin
      n_fail++; $display("FAIL single_bit_crc got %h want 1021", w);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.ocrc !== 1'b0) bad++;
      clk_bit(1'b1, 1'b1);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL drained_zero nonzero_cycles got %0d want 0", bad);
    end
  endtask

  task automatic test_check_string();
    logic [15:0] w;
    pulse_reset();
    feed_string();
    unload16(w);
    n_tests++;
    if (w !== 16'h31C3) begin
      n_fail++; $display("FAIL check_string got %h want 31c3", w);
    end
  endtask

  task automatic test_ones();
    logic [15:0] w;
    pulse_reset();
    for (int i = 0; i < 4096; i++) clk_bit(1'b1, 1'b0);
    unload16(w);
    n_tests++;
    if (w !== 16'h7FA1) begin
      n_fail++; $display("FAIL ones_4096 got %h want 7fa1", w);
    end
  endtask

  task automatic test_zeros();
    logic [15:0] w;
    int bad;
    pulse_reset();
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      clk_bit(1'b0, 1'b0);
      if (bus.ocrc !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL zeros_stream nonzero_cycles got %0d want 0", bad);
    end
    unload16(w);
    n_tests++;
    if (w !== 16'h0000) begin
      n_fail++; $display("FAIL zeros_crc got %h want 0000", w);
    end
  endtask

  task automatic test_partial_unload();
    logic [15:0] w;
    pulse_reset();
    clk_bit(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) clk_bit(1'b0, 1'b1);
    clk_bit(1'b0, 1'b0);
    unload16(w);
    n_tests++;
    if (w !== 16'h0420) begin
      n_fail++; $display("FAIL partial_resume got %h want 0420", w);
    end
  endtask

  task automatic test_append();
    logic [15:0] crc_word;
    logic [15:0] w;
    int bad;
    crc_word = 16'h31C3;
    pulse_reset();
    feed_string();
    for (int i = 15; i >= 0; i--) clk_bit(crc_word[i], 1'b0);
    n_tests++;
    if (bus.ocrc !== 1'b0) begin
      n_fail++; $display("FAIL append_msb got %b want 0", bus.ocrc);
    end
    unload16(w);
    n_tests++;
    if (w !== 16'h0000) begin
      n_fail++; $display("FAIL append_residue got %h want 0000", w);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.ocrc !== 1'b0) bad++;
      clk_bit(1'b0, 1'b1);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL append_no_wrap nonzero_cycles got %0d want 0", bad);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    bus.idata = 1'b0;
    bus.iunload = 1'b0;
    irst = 1'b1;
    #13;
    irst = 1'b0;
    test_reset();
    test_single_bit();
    test_check_string();
    test_ones();
    test_zeros();
    test_partial_unload();
    test_append();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
